// File: rtl/fence_arbiter_pkg.sv
// Shared state encoding, widths and helpers for the fence-engine arbiter.
package fence_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int COORD_W  = 8;
    localparam int NPTS_DEF = 6;
    localparam int IDX_W    = 3;

    // Successor of idx modulo n.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int n);
        return (int'(idx) >= n - 1) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/fence_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester found searching from last+1.
module rr_pick
    import fence_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    logic [IDX_W-1:0]  w_start;
    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;

    // Rotate so that bit 0 is the requester right after the last owner.
    assign w_start = next_idx(i_last, NREQ);
    assign w_dbl   = {i_req, i_req};
    assign w_rot   = NREQ'(w_dbl >> w_start);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_found && w_rot[k]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'((int'(w_start) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/fence_arbiter.sv
// Round-robin owner of the fence-sorting engine: loads one requester's points,
// returns the engine's answer beats tagged with the owner id, aborts on a silent engine.
module fence_arbiter
    import fence_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int NPTS    = NPTS_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NREQ-1:0]           i_req,
    input  logic [NREQ-1:0]           i_req_valid,
    input  logic [NREQ*COORD_W-1:0]   i_req_x,
    input  logic [NREQ*COORD_W-1:0]   i_req_y,
    output logic [NREQ-1:0]           o_grant,
    output logic                      o_busy,
    output logic                      o_eng_give_valid,
    output logic [COORD_W-1:0]        o_eng_dataX,
    output logic [COORD_W-1:0]        o_eng_dataY,
    output logic                      o_eng_reset,
    input  logic [COORD_W-1:0]        i_eng_ansX,
    input  logic [COORD_W-1:0]        i_eng_ansY,
    input  logic                      i_eng_out_valid,
    output logic                      o_resp_valid,
    output logic [COORD_W-1:0]        o_resp_x,
    output logic [COORD_W-1:0]        o_resp_y,
    output logic [IDX_W-1:0]          o_resp_id,
    output logic                      o_resp_last,
    output logic                      o_timeout_err
);

    localparam int CNT_W = 3;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    state_t             r_state;
    logic [NREQ-1:0]    r_grant;
    logic [IDX_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic [WD_W-1:0]    r_wdog;
    logic               r_resp_valid;
    logic [COORD_W-1:0] r_resp_x;
    logic [COORD_W-1:0] r_resp_y;
    logic [IDX_W-1:0]   r_resp_id;
    logic               r_resp_last;
    logic               r_eng_reset;
    logic               r_timeout_err;

    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_found;
    logic               w_load;
    logic               w_own_vld;
    logic [COORD_W-1:0] w_own_x;
    logic [COORD_W-1:0] w_own_y;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (i_req),
        .i_last  (r_last),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // Grant is one-hot, so masking selects the owner's lane without an index mux.
    always_comb begin
        w_own_vld = |(i_req_valid & r_grant);
        w_own_x   = '0;
        w_own_y   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_own_x |= i_req_x[i*COORD_W +: COORD_W];
                w_own_y |= i_req_y[i*COORD_W +: COORD_W];
            end
        end
    end

    assign w_load           = (r_state == ST_LOAD);
    assign o_eng_give_valid = w_load && w_own_vld;
    assign o_eng_dataX      = w_load ? w_own_x : '0;
    assign o_eng_dataY      = w_load ? w_own_y : '0;

    assign o_busy        = (r_state != ST_IDLE);
    assign o_grant       = r_grant;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_x      = r_resp_x;
    assign o_resp_y      = r_resp_y;
    assign o_resp_id     = r_resp_id;
    assign o_resp_last   = r_resp_last;
    assign o_eng_reset   = r_eng_reset;
    assign o_timeout_err = r_timeout_err;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_last        <= IDX_W'(NREQ - 1);
            r_cnt         <= '0;
            r_wdog        <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_x      <= '0;
            r_resp_y      <= '0;
            r_resp_id     <= '0;
            r_resp_last   <= 1'b0;
            r_eng_reset   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_resp_valid  <= 1'b0;
            r_resp_last   <= 1'b0;
            r_eng_reset   <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        r_grant <= NREQ'(1) << w_pick_idx;
                        r_last  <= w_pick_idx;
                        r_cnt   <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (o_eng_give_valid) begin
                        if (r_cnt == CNT_W'(NPTS - 1)) begin
                            r_cnt   <= '0;
                            r_wdog  <= '0;
                            r_state <= ST_RUN;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (i_eng_out_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_x     <= i_eng_ansX;
                        r_resp_y     <= i_eng_ansY;
                        r_resp_id    <= r_last;
                        r_wdog       <= '0;
                        if (r_cnt == CNT_W'(NPTS - 1)) begin
                            r_resp_last <= 1'b1;
                            r_cnt       <= '0;
                            r_grant     <= '0;
                            r_state     <= ST_GAP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                        // Engine went silent: clear it and give the slot back.
                        r_eng_reset   <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_grant       <= '0;
                        r_cnt         <= '0;
                        r_wdog        <= '0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
